dpram_rr_arbiter: RTL and testbench
===================================

Name: dpram_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-access synchronous RAM port among two requesters (req0, req1).
- Each requester presents read/write commands over a valid/ready handshake and receives an in-order response pulse.
- Sits between client logic and the dual-port RAM's combined address/data port; drives that port's enable, write-enable, address and data.
- Fixed pipeline: accept -> RAM command (registered) -> response.

Parameters:
- DATA_WIDTH, 8, RAM word width in bits.
- ADDR_WIDTH, 4, RAM address width in bits (depth 2**ADDR_WIDTH).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 command valid.
- req0_ready  output  1  requester 0 command accepted this cycle (combinational grant).
- req0_we  input  1  1 = write, 0 = read.
- req0_addr  input  ADDR_WIDTH  command address.
- req0_wdata  input  DATA_WIDTH  write data.
- rsp0_valid  output  1  one-cycle response pulse for requester 0.
- rsp0_rdata  output  DATA_WIDTH  read data, valid with rsp0_valid on reads; 0 otherwise.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- ram_en  output  1  RAM access strobe.
- ram_we  output  1  RAM write enable (qualified by ram_en).
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after ram_en with ram_we = 0.

Behaviour:
- Reset (rst = 1 at posedge):
  - ram_en, ram_we, ram_addr, ram_wdata = 0.
  - rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata = 0.
  - Last-grant pointer = 1, so req0 has priority first.
  - In-flight commands are discarded; no response pulses for them after reset.
- While rst is high, req0_ready = req1_ready = 0.
- Arbitration (combinational, every cycle):
  - Only one valid: grant it.
  - Both valid: grant the requester that was not granted last.
  - Neither valid: no grant.
  - At most one of req0_ready / req1_ready is high. reqX_ready never asserts without reqX_valid.
- Pointer update: on every grant, last-grant = granted id. It is unchanged when idle.
- Fairness: a continuously asserted request waits at most 1 cycle.
- Handshake: a command transfers on a cycle with valid && ready.
  - The requester must hold valid, we, addr and wdata stable until ready.
  - Deasserting valid before ready is permitted (request withdrawn, no effect).
- Pipeline, for a command accepted in cycle N:
  - N+1: ram_en = 1, ram_we = cmd we, ram_addr / ram_wdata = cmd fields (registered). Owner id and we are carried in a pipeline stage.
  - N+2: rsp<owner>_valid = 1 for one cycle. On a read, rsp<owner>_rdata = ram_rdata (combinational passthrough). On a write, rsp_rdata = 0.
  - Cycles with no accepted command: ram_en = 0, ram_we = 0. ram_addr and ram_wdata hold their previous values.
- Throughput: one command per cycle sustained; back-to-back commands are fully pipelined.
- Ordering: responses return in acceptance order. The two rsp_valid signals are never both high.
- Read-after-write: a write accepted in N commits at the end of N+1. A read to the same address accepted in N+1 or later returns the new data. No forwarding logic required.
- No response backpressure: rsp_valid is a pulse and must be consumed when it occurs.
- rst asserted mid-stream clears both pipeline stages on that edge.

Test Plan:
- Reset, then req0 write addr 3 data 0xA5 in cycle 2 -> req0_ready = 1 in cycle 2. Cycle 3: ram_en = 1, ram_we = 1, ram_addr = 3, ram_wdata = 0xA5. Cycle 4: rsp0_valid = 1, rsp0_rdata = 0.
- req1 read addr 3 after the above write (RAM model returns stored data) -> cycle N+1: ram_en = 1, ram_we = 0. Cycle N+2: rsp1_valid = 1, rsp1_rdata = 0xA5, rsp0_valid = 0.
- Both valid continuously from reset, req0 reads addr 0..3 and req1 reads addr 8..11 -> grants alternate 0,1,0,1 starting with req0. ram_addr sequence 0,8,1,9,2,10,3,11. Responses alternate with the same ordering at +2 cycles.
- Back-to-back: req0 writes addr 5 = 0x3C in cycle N, then reads addr 5 in N+1 -> ram_en high in N+1 and N+2. rsp0_valid high in N+2 (write, rdata 0) and N+3 (rdata 0x3C).
- Assert rst one cycle after accepting a read (command in RAM stage) -> rsp0_valid and rsp1_valid stay 0 thereafter. ram_en = 0 after the reset edge. Next simultaneous request grants req0 first.
- Only req1 valid for 4 cycles, then both valid -> req1 granted 4 times, then req0 granted next (pointer = 1). No cycle has both readies high.

Source files
------------

// File: rtl/dpram_rr_arbiter_if.sv
// Bundle of the two requester command/response channels and the shared RAM port.
// The master side is client logic plus the RAM; the slave side is the arbiter.
interface dpram_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/dpram_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one synchronous RAM port.
// Accept -> registered RAM command -> in-order response pulse two cycles after acceptance.
module dpram_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  dpram_rr_arbiter_if.slave bus
);

  logic                  last_grant;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  vld_p0;
  logic                  we_p0;
  logic                  owner_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;

  logic                  vld_p1;
  logic                  we_p1;
  logic                  owner_p1;

  // Arbitration: a lone request wins; on contention the requester not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant))
        grant0 = 1'b1;
      else if (bus.req1_valid)
        grant1 = 1'b1;
    end
  end

  assign accept    = grant0 | grant1;
  assign sel_we    = grant1 ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      vld_p0     <= 1'b0;
      we_p0      <= 1'b0;
      owner_p0   <= 1'b0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      vld_p1     <= 1'b0;
      we_p1      <= 1'b0;
      owner_p1   <= 1'b0;
    end else begin
      // Stage p0: RAM command register; address and data hold when idle
      vld_p0 <= accept;
      we_p0  <= accept & sel_we;
      if (accept) begin
        last_grant <= grant1;
        owner_p0   <= grant1;
        addr_p0    <= sel_addr;
        wdata_p0   <= sel_wdata;
      end
      // Stage p1: response tag, aligned with the RAM read data
      vld_p1   <= vld_p0;
      we_p1    <= we_p0;
      owner_p1 <= owner_p0;
    end
  end

  assign bus.ram_en    = vld_p0;
  assign bus.ram_we    = we_p0;
  assign bus.ram_addr  = addr_p0;
  assign bus.ram_wdata = wdata_p0;

  assign bus.rsp0_valid = vld_p1 & ~owner_p1;
  assign bus.rsp1_valid = vld_p1 &  owner_p1;
  assign bus.rsp0_rdata = (vld_p1 && !owner_p1 && !we_p1) ? bus.ram_rdata : '0;
  assign bus.rsp1_rdata = (vld_p1 &&  owner_p1 && !we_p1) ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Bench for dpram_rr_arbiter: directed scenarios plus a randomized run
// against a transaction-level model with a behavioural RAM attached.
module tb_dpram_rr_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dpram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural single-port synchronous RAM
  logic [DW-1:0] ram_mem [2**AW] = '{default: '0};
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_q <= ram_mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = ram_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  // Apply inputs just after the falling edge; observe 1 ns later, far from the rising edge.
  task automatic drive(input logic r,
                       input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(negedge clk);
    rst            = r;
    bus.req0_valid = v0;
    bus.req0_we    = we0;
    bus.req0_addr  = a0;
    bus.req0_wdata = d0;
    bus.req1_valid = v1;
    bus.req1_we    = we1;
    bus.req1_addr  = a1;
    bus.req1_wdata = d1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd8, 8'h00);
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    drive(1'b1, 1'b1, 1'b1, 4'd1, 8'hFF, 1'b1, 1'b1, 4'd9, 8'hEE);
    checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_ram: got en=%b we=%b addr=%h wdata=%h want all 0",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata} !== '0) begin
      errors++;
      $display("FAIL rst_rsp: got v0=%b v1=%b d0=%h d1=%h want all 0",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata);
    end
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready_hold: got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00);
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL wr_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    idle();
    checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 1'b1, 4'd3, 8'hA5}) begin
      errors++;
      $display("FAIL wr_ram: got en=%b we=%b addr=%h wdata=%h want 1 1 3 a5",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00);
    checks++;
    if ({bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL wr_rsp: got v0=%b d0=%h v1=%b want 1 00 0", bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid);
    end
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_ready: got %b%b want 01", bus.req0_ready, bus.req1_ready);
    end
    idle();
    checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.rsp0_valid} !== {1'b1, 1'b0, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL rd_ram: got en=%b we=%b addr=%h rsp0=%b want 1 0 3 0",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.rsp0_valid);
    end
    idle();
    checks++;
    if ({bus.rsp1_valid, bus.rsp1_rdata, bus.rsp0_valid} !== {1'b1, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL rd_rsp: got v1=%b d1=%h v0=%b want 1 a5 0", bus.rsp1_valid, bus.rsp1_rdata, bus.rsp0_valid);
    end
  endtask

  task automatic test_alternate();
    int n0 = 0;
    int n1 = 0;
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, n0 < 4, 1'b0, AW'(n0), 8'h00, n1 < 4, 1'b0, AW'(8 + n1), 8'h00);
      if (i < 8) begin
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL alt_grant i=%0d: got %b%b want grant to req%0d", i, bus.req0_ready, bus.req1_ready, i % 2);
        end
        if (i % 2 == 0) n0++;
        else            n1++;
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if ({bus.ram_en, bus.ram_addr} !== {1'b1, AW'(((i - 1) % 2 == 0) ? (i - 1) / 2 : 8 + (i - 1) / 2)}) begin
          errors++;
          $display("FAIL alt_addr i=%0d: got en=%b addr=%0d", i, bus.ram_en, bus.ram_addr);
        end
      end
      if (i >= 2 && i <= 9) begin
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid} !== (((i - 2) % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL alt_rsp i=%0d: got %b%b", i, bus.rsp0_valid, bus.rsp1_valid);
        end
      end
      if (i == 10) begin
        checks++;
        if ({bus.ram_en, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
          errors++;
          $display("FAIL alt_drain: got en=%b rsp=%b%b want 000", bus.ram_en, bus.rsp0_valid, bus.rsp1_valid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b0, '0, '0);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wr_ready: got %b want 1", bus.req0_ready);
    end
    drive(1'b0, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, '0, '0);
    checks++;
    if ({bus.req0_ready, bus.ram_en, bus.ram_we} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_rd_ready: got ready=%b en=%b we=%b want 111", bus.req0_ready, bus.ram_en, bus.ram_we);
    end
    idle();
    checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.rsp0_valid, bus.rsp0_rdata} !== {1'b1, 1'b0, 4'd5, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL b2b_n2: got en=%b we=%b addr=%h rsp0=%b d0=%h want 1 0 5 1 00",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.rsp0_valid, bus.rsp0_rdata);
    end
    idle();
    checks++;
    if ({bus.ram_en, bus.ram_we, bus.rsp0_valid, bus.rsp0_rdata} !== {1'b0, 1'b0, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL b2b_n3: got en=%b we=%b rsp0=%b d0=%h want 0 0 1 3c",
               bus.ram_en, bus.ram_we, bus.rsp0_valid, bus.rsp0_rdata);
    end
    idle();
    checks++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.ram_addr} !== {2'b00, 4'd5}) begin
      errors++;
      $display("FAIL b2b_n4: got rsp=%b%b addr=%h want 00 addr held at 5", bus.rsp0_valid, bus.rsp1_valid, bus.ram_addr);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, '0, '0);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_accept: got %b want 1", bus.req0_ready);
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (bus.ram_en !== 1'b1) begin
      errors++;
      $display("FAIL rm_inflight: got en=%b want 1", bus.ram_en);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if ({bus.ram_en, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
        errors++;
        $display("FAIL rm_flush i=%0d: got en=%b rsp=%b%b want 000", i, bus.ram_en, bus.rsp0_valid, bus.rsp1_valid);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rm_pointer: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
  endtask

  task automatic test_req1_only();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), 8'h00);
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
        errors++;
        $display("FAIL r1_only i=%0d: got %b%b want 01", i, bus.req0_ready, bus.req1_ready);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 4'd6, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00);
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL r1_then_both: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    drive(1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00);
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL r1_fair: got %b%b want 01", bus.req0_ready, bus.req1_ready);
    end
    idle();
    idle();
    idle();
  endtask

  task automatic test_random();
    logic [DW-1:0] mm [2**AW];
    logic          p_v  [2];
    logic          p_we [2];
    logic [AW-1:0] p_a  [2];
    logic [DW-1:0] p_d  [2];
    exp_t          cmd_q [int];
    exp_t          rsp_q [int];
    exp_t          e;
    int            last = 1;
    int            g;
    logic          want0;
    logic          want1;
    for (int i = 0; i < 2**AW; i++) mm[i] = '0;
    mm[3] = 8'hA5;
    mm[5] = 8'h3C;
    for (int r = 0; r < 2; r++) begin
      p_v[r] = 1'b0; p_we[r] = 1'b0; p_a[r] = '0; p_d[r] = '0;
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int ph = 0; ph < 403; ph++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_v[r]) begin
          if (ph < 400 && $urandom_range(0, 99) < 60) begin
            p_v[r]  = 1'b1;
            p_we[r] = 1'($urandom_range(0, 1));
            p_a[r]  = AW'($urandom);
            p_d[r]  = DW'($urandom);
          end
        end else if ($urandom_range(0, 99) < 5) begin
          p_v[r] = 1'b0;
        end
      end
      drive(1'b0, p_v[0], p_we[0], p_a[0], p_d[0], p_v[1], p_we[1], p_a[1], p_d[1]);
      if (p_v[0] && p_v[1]) g = (last == 0) ? 1 : 0;
      else if (p_v[0])      g = 0;
      else if (p_v[1])      g = 1;
      else                  g = -1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {g == 0, g == 1}) begin
        errors++;
        $display("FAIL rnd_grant ph=%0d: got %b%b want req%0d", ph, bus.req0_ready, bus.req1_ready, g);
      end
      checks++;
      if (cmd_q.exists(ph)) begin
        e = cmd_q[ph];
        if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {1'b1, e.we, e.addr} ||
            (e.we && bus.ram_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL rnd_cmd ph=%0d: got en=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
                   ph, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, e.we, e.addr, e.wdata);
        end
        cmd_q.delete(ph);
      end else if ({bus.ram_en, bus.ram_we} !== 2'b00) begin
        errors++;
        $display("FAIL rnd_cmd ph=%0d: got en=%b we=%b want 00", ph, bus.ram_en, bus.ram_we);
      end
      want0 = rsp_q.exists(ph) && rsp_q[ph].owner == 1'b0;
      want1 = rsp_q.exists(ph) && rsp_q[ph].owner == 1'b1;
      checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== {want0, want1}) begin
        errors++;
        $display("FAIL rnd_rsp ph=%0d: got %b%b want %b%b", ph, bus.rsp0_valid, bus.rsp1_valid, want0, want1);
      end
      if (rsp_q.exists(ph)) begin
        e = rsp_q[ph];
        checks++;
        if ((e.owner ? bus.rsp1_rdata : bus.rsp0_rdata) !== e.rdata) begin
          errors++;
          $display("FAIL rnd_rdata ph=%0d req%0d: got %h want %h", ph, e.owner,
                   e.owner ? bus.rsp1_rdata : bus.rsp0_rdata, e.rdata);
        end
        rsp_q.delete(ph);
      end
      if (g >= 0) begin
        e.owner = (g == 1);
        e.we    = p_we[g];
        e.addr  = p_a[g];
        e.wdata = p_d[g];
        e.rdata = p_we[g] ? '0 : mm[p_a[g]];
        if (p_we[g]) mm[p_a[g]] = p_d[g];
        cmd_q[ph + 1] = e;
        rsp_q[ph + 2] = e;
        last    = g;
        p_v[g]  = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    test_req1_only();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
